// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter
//   Round-robin arbiter for the register file's single write port. Each cycle
//   at most one pending requester is acknowledged, and its address/data are
//   registered as a one-hot write for the register file to consume on the
//   following edge.
//
// Parameters
//   NREQ : number of requesters (2..8)
//   DW   : write data width
//
// Ports
//   clk      : clock, all state on rising edge
//   rst      : synchronous, active-high reset
//   req      : per-requester pending flag
//   addr     : packed 5-bit target registers, requester i in [5i+4:5i]
//   data     : packed write data, requester i in [DW*i+DW-1:DW*i]
//   hold     : register-file stall, blocks new grants
//   ack      : combinational grant (one-hot or zero)
//   we       : registered one-hot write enable
//   wr_addr  : registered write address
//   wr_data  : registered write data
//   wr_valid : registered, high when we carries a write
//   wr_src   : registered index of the owning requester
//   wr_count : committed-write counter, wraps at 16 bits
//
// Optional feature
//   RF_ZERO_REG_PROTECT_EN : when defined, a request to register 0 is acked
//   and consumes its turn, but produces no write and does not update the
//   write registers or the counter.
//
// Handshake: requester i holds req[i] with stable addr/data slices; the
// transfer happens at the rising edge where req[i] && ack[i]. ack is forced
// low while rst or hold is high, so no transfer can happen in those cycles.

module rf_write_arbiter #(
  parameter int NREQ = 4,
  parameter int DW   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*5-1:0] addr,
  input  logic [NREQ*DW-1:0] data,
  input  logic              hold,
  output logic [NREQ-1:0]   ack,
  output logic [31:0]       we,
  output logic [4:0]        wr_addr,
  output logic [DW-1:0]     wr_data,
  output logic              wr_valid,
  output logic [2:0]        wr_src,
  output logic [15:0]       wr_count
);

  localparam logic [2:0] LAST = 3'(NREQ - 1);

  // Round-robin pointer: the requester with highest priority this cycle.
  logic [2:0]    ptr;

  logic          gnt_found;
  logic [2:0]    gnt_idx;
  int            idx;
  logic          accept;
  logic          commit;
  logic [4:0]    sel_addr;
  logic [DW-1:0] sel_data;

  // Scan ptr, ptr+1, ... wrapping at NREQ; first pending requester wins.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    idx       = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!gnt_found && req[idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = 3'(idx);
      end
    end
  end

  always_comb begin
    ack = '0;
    if (gnt_found && !rst && !hold) ack = NREQ'(1) << gnt_idx;
  end

  assign accept   = |(req & ack);
  assign sel_addr = addr[int'(gnt_idx)*5 +: 5];
  assign sel_data = data[int'(gnt_idx)*DW +: DW];

`ifdef RF_ZERO_REG_PROTECT_EN
  // Register 0 is hard-wired: the grant still rotates, but nothing is written.
  assign commit = accept && (sel_addr != 5'd0);
`else
  assign commit = accept;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr      <= '0;
      we       <= '0;
      wr_valid <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      wr_src   <= '0;
      wr_count <= '0;
    end else begin
      // Write strobes are single-cycle; data registers hold between writes.
      we       <= '0;
      wr_valid <= 1'b0;
      if (accept) begin
        ptr <= (gnt_idx == LAST) ? 3'd0 : gnt_idx + 3'd1;
      end
      if (commit) begin
        we       <= 32'd1 << sel_addr;
        wr_valid <= 1'b1;
        wr_addr  <= sel_addr;
        wr_data  <= sel_data;
        wr_src   <= gnt_idx;
        wr_count <= wr_count + 16'd1;
      end
    end
  end

endmodule
